// File: rtl/izh_pkg.sv
// Shared FSM state type, fixed-point constants and multiplier slice positions
// for the time-multiplexed Izhikevich neuron scheduler.
package izh_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_READ,
    S_UPDATE,
    S_EMIT,
    S_DONE
  } state_e;

  // Fixed-point constants in the 0x10000 = 1.0 format, sliced to width by users
  localparam logic [31:0] ONE_RAW = 32'h0001_0000;
  localparam logic [31:0] C14_RAW = 32'h0001_6666;

  // mult() keeps the product sign bit plus bits [2N-4:N-2] of the 2N-bit product
  function automatic int mult_hi(input int n);
    return 2 * n - 4;
  endfunction

  function automatic int mult_lo(input int n);
    return n - 2;
  endfunction

endpackage

// File: rtl/izh_update.sv
// Combinational Izhikevich update: one neuron's (v, u, I) in, next (v, u) and
// spike flag out. All arithmetic wraps at N bits; all shifts are arithmetic.
module izh_update
  import izh_pkg::*;
#(
  parameter int N = 18
) (
  input  logic [N-1:0] v_i,
  input  logic [N-1:0] u_i,
  input  logic [N-1:0] cur_i,
  input  logic [N-1:0] v_th_i,
  input  logic [N-1:0] c_i,
  input  logic [N-1:0] d_i,
  input  logic [4:0]   a_sh_i,
  input  logic [4:0]   b_sh_i,
  output logic [N-1:0] v_o,
  output logic [N-1:0] u_o,
  output logic         spike_o
);

  localparam int MHI = mult_hi(N);
  localparam int MLO = mult_lo(N);
  localparam logic signed [N-1:0] C14 = C14_RAW[N-1:0];

  logic signed [N-1:0]   v_s;
  logic signed [N-1:0]   u_s;
  logic signed [N-1:0]   cur_s;
  logic signed [2*N-1:0] v_ext;
  logic signed [2*N-1:0] prod;
  logic signed [N-1:0]   vsq;
  logic signed [N-1:0]   dv_sum;
  logic signed [N-1:0]   u_diff;
  logic signed [N-1:0]   du;
  logic                  prod_unused;

  always_comb begin
    v_s         = $signed(v_i);
    u_s         = $signed(u_i);
    cur_s       = $signed(cur_i);
    v_ext       = {{N{v_i[N-1]}}, v_i};
    prod        = v_ext * v_ext;
    vsq         = {prod[2*N-1], prod[MHI:MLO]};
    prod_unused = ^{prod[2*N-2:MHI+1], prod[MLO-1:0]};
    dv_sum      = vsq + v_s + (v_s >>> 2) + (C14 >>> 2) - (u_s >>> 2) + (cur_s >>> 2);
    u_diff      = (v_s >>> b_sh_i) - u_s;
    du          = (u_diff >>> a_sh_i) >>> 4;
    spike_o     = v_s > $signed(v_th_i);
    if (spike_o) begin
      v_o = c_i;
      u_o = u_i + d_i;
    end else begin
      v_o = v_s + (dv_sum >>> 2);
      u_o = u_s + du;
    end
  end

endmodule

// File: rtl/izhikevich_scheduler.sv
// Sweeps one shared Izhikevich datapath over a neuron population per step
// request, writing state back and streaming spike events over valid/ready.
module izhikevich_scheduler
  import izh_pkg::*;
#(
  parameter int N           = 18,
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             init,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [N-1:0]     cfg_i,
  input  logic [N-1:0]     v_init,
  input  logic [N-1:0]     u_init,
  input  logic [N-1:0]     v_th,
  input  logic [N-1:0]     c,
  input  logic [N-1:0]     d,
  input  logic [4:0]       a_sh,
  input  logic [4:0]       b_sh,
  output logic             busy,
  output logic             step_done,
  output logic [IDX_W:0]   spike_count,
  output logic             spk_valid,
  output logic [IDX_W-1:0] spk_idx,
  input  logic             spk_ready
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] spk_idx_q, spk_idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [IDX_W:0]   spike_count_q, spike_count_d;
  logic             spk_valid_q, spk_valid_d;

  logic [N-1:0] v_q [NUM_NEURONS];
  logic [N-1:0] u_q [NUM_NEURONS];
  logic [N-1:0] i_q [NUM_NEURONS];
  logic [N-1:0] opv_q, opu_q, opi_q;

  logic [N-1:0] v_new, u_new;
  logic         spike;
  logic         is_last;

  izh_update #(.N(N)) u_update (
    .v_i     (opv_q),
    .u_i     (opu_q),
    .cur_i   (opi_q),
    .v_th_i  (v_th),
    .c_i     (c),
    .d_i     (d),
    .a_sh_i  (a_sh),
    .b_sh_i  (b_sh),
    .v_o     (v_new),
    .u_o     (u_new),
    .spike_o (spike)
  );

  assign is_last     = (idx_q == LAST);
  assign busy        = (state_q != S_IDLE);
  assign step_done   = (state_q == S_DONE);
  assign spike_count = spike_count_q;
  assign spk_valid   = spk_valid_q;
  assign spk_idx     = spk_idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_INIT;
      idx_q         <= '0;
      cnt_q         <= '0;
      spike_count_q <= '0;
      spk_valid_q   <= 1'b0;
      spk_idx_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      spike_count_q <= spike_count_d;
      spk_valid_q   <= spk_valid_d;
      spk_idx_q     <= spk_idx_d;
    end
  end

  // spike_count is published on entry to DONE so it is valid alongside step_done
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    spike_count_d = spike_count_q;
    spk_valid_d   = spk_valid_q;
    spk_idx_d     = spk_idx_q;
    case (state_q)
      S_IDLE: begin
        if (step) begin
          state_d = S_READ;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (init) begin
          state_d = S_INIT;
          idx_d   = '0;
        end
      end
      S_INIT: begin
        if (is_last) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_READ: state_d = S_UPDATE;
      S_UPDATE: begin
        if (spike) begin
          state_d     = S_EMIT;
          spk_valid_d = 1'b1;
          spk_idx_d   = idx_q;
          cnt_d       = cnt_q + 1'b1;
        end else if (is_last) begin
          state_d       = S_DONE;
          spike_count_d = cnt_q;
        end else begin
          state_d = S_READ;
          idx_d   = idx_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (spk_ready) begin
          spk_valid_d = 1'b0;
          if (is_last) begin
            state_d       = S_DONE;
            spike_count_d = cnt_q;
          end else begin
            state_d = S_READ;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        i_q[k] <= '0;
      end
    end else if (state_q == S_IDLE && cfg_we) begin
      i_q[cfg_idx] <= cfg_i;
    end
  end

  // State arrays and operand registers need no reset; INIT reloads v/u after reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      case (state_q)
        S_INIT: begin
          v_q[idx_q] <= v_init;
          u_q[idx_q] <= u_init;
        end
        S_READ: begin
          opv_q <= v_q[idx_q];
          opu_q <= u_q[idx_q];
          opi_q <= i_q[idx_q];
        end
        S_UPDATE: begin
          v_q[idx_q] <= v_new;
          u_q[idx_q] <= u_new;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_izhikevich_scheduler.sv
// Self-checking bench for izhikevich_scheduler against an arithmetic reference
// model of the Izhikevich population update.
module tb_izhikevich_scheduler;

  localparam int N  = 18;
  localparam int NN = 16;
  localparam int IW = 4;
  localparam longint C14 = 64'sh16666;

  logic          clk = 1'b0;
  logic          reset, step, init, cfg_we, spk_ready;
  logic [IW-1:0] cfg_idx;
  logic [N-1:0]  cfg_i, v_init, u_init, v_th, c, d;
  logic [4:0]    a_sh, b_sh;
  logic          busy, step_done, spk_valid;
  logic [IW:0]   spike_count;
  logic [IW-1:0] spk_idx;

  izhikevich_scheduler #(.N(N), .NUM_NEURONS(NN)) dut (
    .clk         (clk),
    .reset       (reset),
    .step        (step),
    .init        (init),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_i       (cfg_i),
    .v_init      (v_init),
    .u_init      (u_init),
    .v_th        (v_th),
    .c           (c),
    .d           (d),
    .a_sh        (a_sh),
    .b_sh        (b_sh),
    .busy        (busy),
    .step_done   (step_done),
    .spike_count (spike_count),
    .spk_valid   (spk_valid),
    .spk_idx     (spk_idx),
    .spk_ready   (spk_ready)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     passed = 0;
  longint mv[NN], mu[NN], mi[NN];
  int     exp_ev[$];
  int     ev_q[$];

  function automatic longint sx(input logic [N-1:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint wrap(input longint x);
    longint r;
    r = x & 64'h3FFFF;
    if (r >= 64'h20000) r = r - 64'h40000;
    return r;
  endfunction

  // Fixed-point square: product bits 32..16 with the product's sign on top
  function automatic longint fmult(input longint x, input longint y);
    longint p, lo;
    p  = x * y;
    lo = (p >>> 16) & 64'h1FFFF;
    return (p < 0) ? lo - 64'h20000 : lo;
  endfunction

  function automatic void model_init();
    for (int k = 0; k < NN; k++) begin
      mv[k] = sx(v_init);
      mu[k] = sx(u_init);
    end
  endfunction

  function automatic void model_step();
    longint v, u, s, t;
    exp_ev.delete();
    for (int k = 0; k < NN; k++) begin
      v = mv[k];
      u = mu[k];
      if (v > sx(v_th)) begin
        mv[k] = sx(c);
        mu[k] = wrap(u + sx(d));
        exp_ev.push_back(k);
      end else begin
        s     = wrap(fmult(v, v) + v + (v >>> 2) + (C14 >>> 2) - (u >>> 2) + (mi[k] >>> 2));
        mv[k] = wrap(v + (s >>> 2));
        t     = wrap((v >>> b_sh) - u);
        mu[k] = wrap(u + ((t >>> a_sh) >>> 4));
      end
    end
  endfunction

  function automatic bit events_match();
    if (ev_q.size() != exp_ev.size()) return 1'b0;
    for (int k = 0; k < ev_q.size(); k++) begin
      if (ev_q[k] != exp_ev[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one step and follows the sweep to step_done; cycles=-1 on timeout
  task automatic run_step(input int stall_idx, input int stall_n, input int inject_at,
                          input bit rand_ready, output int cycles, output int stalled);
    int cyc, remaining;
    ev_q.delete();
    cycles    = -1;
    stalled   = 0;
    remaining = stall_n;
    cyc       = 0;
    spk_ready = 1'b1;
    step      = 1'b1;
    while (cyc < 3000) begin
      cycle();
      cyc++;
      step   = 1'b0;
      init   = 1'b0;
      cfg_we = 1'b0;
      if (cyc == inject_at) begin
        step    = 1'b1;
        init    = 1'b1;
        cfg_we  = 1'b1;
        cfg_idx = 4'd5;
        cfg_i   = 18'h1FFFF;
      end
      if (step_done) begin
        cycles = cyc;
        break;
      end
      spk_ready = 1'b1;
      if (spk_valid) begin
        if (remaining > 0 && int'(spk_idx) == stall_idx) begin
          spk_ready = 1'b0;
          remaining--;
          stalled++;
        end else if (rand_ready && $urandom_range(0, 1) == 0) begin
          spk_ready = 1'b0;
        end else begin
          ev_q.push_back(int'(spk_idx));
        end
      end
    end
    step      = 1'b0;
    init      = 1'b0;
    cfg_we    = 1'b0;
    spk_ready = 1'b1;
  endtask

  task automatic do_init(output int n);
    init = 1'b1;
    cycle();
    init = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      cycle();
      n++;
    end
    model_init();
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    step = 1'b0; init = 1'b0; cfg_we = 1'b0; spk_ready = 1'b1;
    cfg_idx = '0; cfg_i = '0;
    cycle();
    cycle();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b1 || step_done !== 1'b0 || spk_valid !== 1'b0)
      $display("[TB] FAIL reset_flags: busy=%b done=%b valid=%b want 1 0 0", busy, step_done, spk_valid);
    else passed++;
    checks++;
    if (spike_count !== '0 || spk_idx !== '0)
      $display("[TB] FAIL reset_values: count=%0d idx=%0d want 0 0", spike_count, spk_idx);
    else passed++;
    n = 0;
    while (busy && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (n != NN) $display("[TB] FAIL reset_init_len: busy for %0d cycles want %0d", n, NN);
    else passed++;
    model_init();
    for (int k = 0; k < NN; k++) mi[k] = 0;
  endtask

  task automatic check_state(input string tag);
    logic [N-1:0] ev, eu;
    for (int k = 0; k < NN; k++) begin
      ev = mv[k][N-1:0];
      eu = mu[k][N-1:0];
      checks++;
      if (dut.v_q[k] !== ev) $display("[TB] FAIL %s_v[%0d]: got %h want %h", tag, k, dut.v_q[k], ev);
      else passed++;
      checks++;
      if (dut.u_q[k] !== eu) $display("[TB] FAIL %s_u[%0d]: got %h want %h", tag, k, dut.u_q[k], eu);
      else passed++;
    end
  endtask

  task automatic test_quiet_step();
    int cyc, st;
    run_step(-1, 0, 0, 1'b0, cyc, st);
    model_step();
    checks++;
    if (cyc != 2 * NN + 1) $display("[TB] FAIL quiet_latency: got %0d want %0d", cyc, 2 * NN + 1);
    else passed++;
    checks++;
    if (!events_match()) $display("[TB] FAIL quiet_events: got %0d events want %0d", ev_q.size(), exp_ev.size());
    else passed++;
    cycle();
    checks++;
    if (spike_count !== (IW+1)'(exp_ev.size()) || busy !== 1'b0)
      $display("[TB] FAIL quiet_count: count=%0d busy=%b want %0d 0", spike_count, busy, exp_ev.size());
    else passed++;
    check_state("quiet");
  endtask

  task automatic test_all_spike();
    int cyc, st, n;
    v_th = 18'h30000; c = 18'h38000; d = 18'h0051E;
    do_init(n);
    checks++;
    if (n != NN) $display("[TB] FAIL init_len: got %0d want %0d", n, NN);
    else passed++;
    run_step(-1, 0, 0, 1'b0, cyc, st);
    model_step();
    checks++;
    if (!events_match() || ev_q.size() != NN)
      $display("[TB] FAIL all_events: got %0d events want %0d in order", ev_q.size(), exp_ev.size());
    else passed++;
    checks++;
    if (cyc < 2 * NN + 1 + NN) $display("[TB] FAIL all_latency: got %0d want >= %0d", cyc, 3 * NN + 1);
    else passed++;
    cycle();
    checks++;
    if (spike_count !== (IW+1)'(NN)) $display("[TB] FAIL all_count: got %0d want %0d", spike_count, NN);
    else passed++;
    check_state("all");
  endtask

  task automatic test_backpressure();
    int base, cyc, st, n;
    do_init(n);
    run_step(-1, 0, 0, 1'b0, base, st);
    model_step();
    cycle();
    do_init(n);
    run_step(0, 5, 0, 1'b0, cyc, st);
    model_step();
    checks++;
    if (st != 5) $display("[TB] FAIL bp_stall: valid held for %0d stalled cycles want 5", st);
    else passed++;
    checks++;
    if (!events_match()) $display("[TB] FAIL bp_events: got %0d events want %0d", ev_q.size(), exp_ev.size());
    else passed++;
    checks++;
    if (base < 0 || cyc != base + 5) $display("[TB] FAIL bp_delay: got %0d want %0d", cyc, base + 5);
    else passed++;
    cycle();
  endtask

  task automatic test_busy_ignore();
    int cyc, st, n, idle;
    v_th = 18'h04CCC;
    do_init(n);
    run_step(-1, 0, 10, 1'b0, cyc, st);
    model_step();
    checks++;
    if (cyc != 2 * NN + 1) $display("[TB] FAIL busy_latency: got %0d want %0d", cyc, 2 * NN + 1);
    else passed++;
    idle = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (busy === 1'b0) idle++;
    end
    checks++;
    if (idle != 3) $display("[TB] FAIL busy_requeue: idle for %0d of 3 cycles", idle);
    else passed++;
    checks++;
    if (dut.i_q[5] !== mi[5][N-1:0]) $display("[TB] FAIL busy_cfg: I[5]=%h want %h", dut.i_q[5], mi[5][N-1:0]);
    else passed++;
    check_state("busy");
  endtask

  task automatic test_cfg_spikes();
    int cyc, st, n, first_dut, first_mod, bad;
    a_sh = 5'd5; b_sh = 5'd2;
    do_init(n);
    cfg_we = 1'b1; cfg_idx = 4'd3; cfg_i = 18'h02666;
    cycle();
    cfg_we = 1'b0;
    mi[3] = sx(18'h02666);
    first_dut = -1; first_mod = -1; bad = 0;
    for (int s = 0; s < 200; s++) begin
      run_step(-1, 0, 0, 1'b0, cyc, st);
      model_step();
      if (!events_match() || cyc < 0) bad++;
      if (first_dut < 0 && ev_q.size() > 0) first_dut = s;
      if (first_mod < 0 && exp_ev.size() > 0) first_mod = s;
      cycle();
    end
    checks++;
    if (bad != 0) $display("[TB] FAIL cfg_events: %0d of 200 steps differ, want 0", bad);
    else passed++;
    checks++;
    if (first_dut != first_mod) $display("[TB] FAIL cfg_first_spike: step %0d want %0d", first_dut, first_mod);
    else passed++;
    check_state("cfg");
  endtask

  task automatic test_random();
    int cyc, st, bad, n;
    v_init = 18'h30000 + 18'($urandom_range(0, 'h18000));
    u_init = 18'h3C000 + 18'($urandom_range(0, 'h4000));
    v_th   = 18'($urandom_range(0, 'h8000));
    c      = 18'h38000 + 18'($urandom_range(0, 'h4000));
    d      = 18'($urandom_range(0, 'h1000));
    a_sh   = 5'($urandom_range(0, 6));
    b_sh   = 5'($urandom_range(0, 4));
    do_init(n);
    for (int k = 0; k < NN; k++) begin
      cfg_we = 1'b1; cfg_idx = IW'(k); cfg_i = 18'($urandom_range(0, 'hC000));
      mi[k] = sx(cfg_i);
      cycle();
    end
    cfg_we = 1'b0;
    bad = 0;
    for (int s = 0; s < 30; s++) begin
      run_step(-1, 0, 0, 1'b1, cyc, st);
      model_step();
      if (!events_match() || cyc < 0) bad++;
      cycle();
      if (spike_count !== (IW+1)'(exp_ev.size())) bad++;
    end
    checks++;
    if (bad != 0) $display("[TB] FAIL random_steps: %0d discrepancies, want 0", bad);
    else passed++;
    check_state("rand");
  endtask

  task automatic test_reset_mid_sweep();
    int n, cyc, st;
    bit found, saw_done;
    v_th = 18'h30000; c = 18'h38000; d = 18'h0051E;
    cfg_we = 1'b1; cfg_idx = 4'd2; cfg_i = 18'h01234;
    cycle();
    cfg_we = 1'b0;
    do_init(n);
    found = 1'b0;
    step  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      cycle();
      step = 1'b0;
      spk_ready = !(spk_valid && spk_idx == 4'd7);
      if (spk_valid && spk_idx == 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) $display("[TB] FAIL midreset_reach: idx 7 event not seen within bound");
    else passed++;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    spk_ready = 1'b1;
    checks++;
    if (spk_valid !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL midreset_flags: valid=%b busy=%b want 0 1", spk_valid, busy);
    else passed++;
    n = 0; saw_done = 1'b0;
    while (busy && n < 100) begin
      cycle();
      n++;
      if (step_done) saw_done = 1'b1;
    end
    checks++;
    if (n != NN || saw_done) $display("[TB] FAIL midreset_reinit: %0d cycles done=%b want %0d 0", n, saw_done, NN);
    else passed++;
    checks++;
    if (dut.i_q[2] !== '0) $display("[TB] FAIL midreset_iclear: I[2]=%h want 0", dut.i_q[2]);
    else passed++;
    model_init();
    for (int k = 0; k < NN; k++) mi[k] = 0;
    run_step(-1, 0, 0, 1'b0, cyc, st);
    model_step();
    checks++;
    if (!events_match()) $display("[TB] FAIL midreset_step: got %0d events want %0d", ev_q.size(), exp_ev.size());
    else passed++;
    cycle();
  endtask

  initial begin
    v_init = 18'h34CCD; u_init = 18'h3CCCD; v_th = 18'h04CCC;
    c = 18'h38000; d = 18'h0051E; a_sh = 5'd2; b_sh = 5'd2;
    test_reset();
    test_quiet_step();
    test_all_spike();
    test_backpressure();
    test_busy_ignore();
    test_cfg_spikes();
    test_random();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
